// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT stage controller.
// Holds the FSM state encoding, the output-phase log_t code and address width.
package ntt_pkg;

    localparam int ADDR_W = 9;

    localparam logic [3:0] LOG_T_OUTPUT = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        OUTPUT,
        FINISH
    } ntt_state_e;

    // Addresses issued per stage for a given transform and core count.
    function automatic int addr_count(input int log_n, input int log_cc);
        return 1 << (log_n - log_cc - 2);
    endfunction

endpackage

// File: rtl/ntt_controller_if.sv
// Handshake/status bundle between the NTT controller and its router/cores.
// The stall input exists only when NTT_CTRL_STALL_EN is defined.
interface ntt_controller_if;
    import ntt_pkg::*;

    logic              start;
    logic [3:0]        log_m;
    logic [3:0]        log_t;
    logic [ADDR_W-1:0] address_0;
    logic [ADDR_W-1:0] address_1;
    logic              issue;
    logic              bank_sel;
    logic              out_valid;
    logic              busy;
    logic              done;
`ifdef NTT_CTRL_STALL_EN
    logic              stall;

    modport master (
        input  start, stall,
        output log_m, log_t, address_0, address_1,
        output issue, bank_sel, out_valid, busy, done
    );

    modport slave (
        output start, stall,
        input  log_m, log_t, address_0, address_1,
        input  issue, bank_sel, out_valid, busy, done
    );
`else
    modport master (
        input  start,
        output log_m, log_t, address_0, address_1,
        output issue, bank_sel, out_valid, busy, done
    );

    modport slave (
        output start,
        input  log_m, log_t, address_0, address_1,
        input  issue, bank_sel, out_valid, busy, done
    );
`endif

endinterface

// File: rtl/ntt_drain_timer.sv
// Down-counter timing the pipeline drain between butterfly stages.
// load starts a DEPTH-cycle window; expired is high on its last cycle.
module ntt_drain_timer #(
    parameter int DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    logic [7:0] cnt;

    // Load DEPTH-1, then count down and park at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'(DEPTH - 1);
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expired = (cnt == 8'd0);

endmodule

// File: rtl/ntt_controller.sv
// NTT stage sequencer: walks LOG_N butterfly stages, then an output phase.
// Optional freeze input is enabled by defining NTT_CTRL_STALL_EN.
module ntt_controller
    import ntt_pkg::*;
#(
    parameter int LOG_CORE_COUNT = 5,
    parameter int LOG_N          = 12,
    parameter int PIPE_DEPTH     = 8
) (
    input  logic        clk,
    input  logic        rst,
    ntt_controller_if.master bus
);

    localparam int A = addr_count(LOG_N, LOG_CORE_COUNT);

    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(A - 1);
    localparam logic [3:0]        LT_INIT = 4'(LOG_N - 1);

    ntt_state_e        state, state_n;
    logic [ADDR_W-1:0] cnt, cnt_n;
    logic [3:0]        lt, lt_n;
    logic [3:0]        lm, lm_n;
    logic              bank, bank_n;
    logic              load;
    logic              expired;
    logic              frz;

`ifdef NTT_CTRL_STALL_EN
    assign frz = bus.stall;
`else
    assign frz = 1'b0;
`endif

    // Stall during DRAIN only lengthens the drain; issue is idle there anyway.
    ntt_drain_timer #(
        .DEPTH (PIPE_DEPTH)
    ) u_drain (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .expired (expired)
    );

    // Control state: FSM, address counter, stage logs and ping-pong bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            lt    <= LT_INIT;
            lm    <= 4'd0;
            bank  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            lt    <= lt_n;
            lm    <= lm_n;
            bank  <= bank_n;
        end
    end

    // Next-state and counter/log sequencing; everything holds while frozen.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lt_n    = lt;
        lm_n    = lm;
        bank_n  = bank;
        load    = 1'b0;
        if (!frz) begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_n = RUN;
                        cnt_n   = '0;
                        lt_n    = LT_INIT;
                        lm_n    = 4'd0;
                        bank_n  = 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == A_LAST) begin
                        state_n = DRAIN;
                        load    = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (expired) begin
                        cnt_n  = '0;
                        bank_n = ~bank;
                        if (lt != 4'd0) begin
                            lt_n    = lt - 4'd1;
                            lm_n    = lm + 4'd1;
                            state_n = RUN;
                        end else begin
                            lt_n    = LOG_T_OUTPUT;
                            state_n = OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (cnt == A_LAST) begin
                        state_n = FINISH;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state_n = IDLE;
                    lt_n    = LT_INIT;
                    lm_n    = 4'd0;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Registered outputs mirror the current state one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.log_m     <= 4'd0;
            bus.log_t     <= LT_INIT;
            bus.address_0 <= '0;
            bus.address_1 <= '0;
            bus.issue     <= 1'b0;
            bus.bank_sel  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.log_m     <= lm;
            bus.log_t     <= lt;
            bus.address_0 <= cnt;
            bus.address_1 <= cnt;
            bus.issue     <= !frz && (state == RUN || state == OUTPUT);
            bus.bank_sel  <= bank;
            bus.out_valid <= !frz && (state == OUTPUT);
            bus.busy      <= (state == RUN) || (state == DRAIN)
                             || (state == OUTPUT);
            bus.done      <= !frz && (state == FINISH);
        end
    end

endmodule

// File: tb/tb_ntt_controller.sv
// Directed bench for ntt_controller: vector table plus multi-cycle sequences.
// Build with NTT_CTRL_STALL_EN defined to include the freeze sequence.
module tb_ntt_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ntt_controller_if b0 ();
    ntt_controller_if b1 ();

    ntt_controller u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    ntt_controller #(
        .LOG_CORE_COUNT (4),
        .PIPE_DEPTH     (1)
    ) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    typedef struct {
        logic       issue;
        logic [3:0] lt;
        logic [3:0] lm;
        logic [8:0] a0;
        logic [8:0] a1;
        logic       bank;
        logic       ov;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int         cyc;
        logic       issue;
        logic [3:0] lt;
        logic [3:0] lm;
        logic [8:0] addr;
        logic       bank;
        logic       ov;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs [14];
    obs_t tr [0:1023];
    int   nvec = 0;
    int   nmis = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t sample0();
        obs_t o;
        o.issue = b0.issue;
        o.lt    = b0.log_t;
        o.lm    = b0.log_m;
        o.a0    = b0.address_0;
        o.a1    = b0.address_1;
        o.bank  = b0.bank_sel;
        o.ov    = b0.out_valid;
        o.busy  = b0.busy;
        o.done  = b0.done;
        return o;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        nvec++;
        if (got != want) begin
            nmis++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic chk_rst(input string name);
        obs_t o;
        o = sample0();
        nvec++;
        if (o.issue !== 1'b0 || o.lt !== 4'd11 || o.lm !== 4'd0
            || o.a0 !== 9'd0 || o.a1 !== 9'd0 || o.bank !== 1'b0
            || o.ov !== 1'b0 || o.busy !== 1'b0 || o.done !== 1'b0) begin
            nmis++;
            $display("FAIL %s got iss=%0b lt=%0d lm=%0d a0=%0d a1=%0d bk=%0b ov=%0b bsy=%0b dn=%0b want lt=11 rest 0",
                     name, o.issue, o.lt, o.lm, o.a0, o.a1, o.bank,
                     o.ov, o.busy, o.done);
        end
    endtask

    // Pulse start, then record one output snapshot per cycle until done+1.
    task automatic capture(input int maxc, input int restart_at,
                           input int stall_at, input int stall_len,
                           output int done_at);
        done_at = -1;
        b0.start = 1'b1;
        for (int c = 1; c <= maxc; c++) begin
            tick();
            b0.start = (c == restart_at);
`ifdef NTT_CTRL_STALL_EN
            b0.stall = (c >= stall_at) && (c < stall_at + stall_len);
`endif
            tr[c] = sample0();
            if (tr[c].done === 1'b1 && done_at < 0) done_at = c;
            if (done_at > 0 && c >= done_at + 1) break;
        end
        b0.start = 1'b0;
`ifdef NTT_CTRL_STALL_EN
        b0.stall = 1'b0;
`endif
        if (done_at < 0) $display("FAIL capture_bound no done within %0d cycles", maxc);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 14; i++) begin
            obs_t o;
            vec_t v;
            v = vecs[i];
            o = tr[v.cyc];
            nvec++;
            if (o.issue !== v.issue || o.lt !== v.lt || o.lm !== v.lm
                || o.a0 !== v.addr || o.a1 !== v.addr || o.bank !== v.bank
                || o.ov !== v.ov || o.busy !== v.busy || o.done !== v.done) begin
                nmis++;
                $display("FAIL %s vec%0d cyc%0d got iss=%0b lt=%0d lm=%0d a0=%0d a1=%0d bk=%0b ov=%0b bsy=%0b dn=%0b want iss=%0b lt=%0d lm=%0d a=%0d bk=%0b ov=%0b bsy=%0b dn=%0b",
                         tag, i, v.cyc, o.issue, o.lt, o.lm, o.a0, o.a1,
                         o.bank, o.ov, o.busy, o.done, v.issue, v.lt, v.lm,
                         v.addr, v.bank, v.ov, v.busy, v.done);
            end
        end
    endtask

    initial begin
        int d;
        int bad;
        int tog;
        int ovc;
        int iss;
        int dn;

        // cyc, issue, log_t, log_m, addr, bank, out_valid, busy, done
        vecs[0]  = '{1,   1'b0, 4'd11, 4'd0,  9'd0,  1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{2,   1'b1, 4'd11, 4'd0,  9'd0,  1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{33,  1'b1, 4'd11, 4'd0,  9'd31, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{34,  1'b0, 4'd11, 4'd0,  9'd31, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{41,  1'b0, 4'd11, 4'd0,  9'd31, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{42,  1'b1, 4'd10, 4'd1,  9'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{59,  1'b1, 4'd10, 4'd1,  9'd17, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{205, 1'b1, 4'd6,  4'd5,  9'd3,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{442, 1'b1, 4'd0,  4'd11, 9'd0,  1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{481, 1'b0, 4'd0,  4'd11, 9'd31, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{482, 1'b1, 4'd15, 4'd11, 9'd0,  1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{513, 1'b1, 4'd15, 4'd11, 9'd31, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{514, 1'b0, 4'd15, 4'd11, 9'd0,  1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{515, 1'b0, 4'd11, 4'd0,  9'd0,  1'b0, 1'b0, 1'b0, 1'b0};

        b0.start = 1'b0;
        b1.start = 1'b0;
`ifdef NTT_CTRL_STALL_EN
        b0.stall = 1'b0;
        b1.stall = 1'b0;
`endif
        tick();
        tick();
        chk_rst("reset_state");
        rst = 1'b0;
        tick();
        tick();

        // Full transform at defaults.
        capture(700, -1, -1, 0, d);
        chk("latency_default", d, 514);
        check_table("full");
        bad = 0; tog = 0; ovc = 0; iss = 0; dn = 0;
        for (int c = 1; c <= 515; c++) begin
            if (tr[c].issue && !tr[c].ov && (int'(tr[c].lm) + int'(tr[c].lt) != 11)) bad++;
            if (tr[c].ov && tr[c].lt != 4'd15) bad++;
            if (c > 1 && tr[c].bank != tr[c-1].bank) tog++;
            if (tr[c].ov) ovc++;
            if (tr[c].issue) iss++;
            if (tr[c].done) dn++;
        end
        chk("log_sum_bad", bad, 0);
        chk("bank_toggles", tog, 12);
        chk("out_valid_cycles", ovc, 32);
        chk("issue_cycles", iss, 416);
        chk("done_pulses", dn, 1);

        // Second start mid-transform must be ignored.
        tick();
        capture(700, 100, -1, 0, d);
        chk("latency_restart_ignored", d, 514);
        check_table("restart");

        // Reset during stage 5 RUN aborts with no done.
        tick();
        b0.start = 1'b1;
        for (int c = 1; c <= 205; c++) begin
            tick();
            b0.start = 1'b0;
        end
        chk("pre_abort_log_t", int'(b0.log_t), 6);
        rst = 1'b1;
        #1;
        chk_rst("abort_reset_values");
        tick();
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (b0.done) dn++;
        end
        chk("abort_no_done", dn, 0);
        capture(700, -1, -1, 0, d);
        chk("replay_latency", d, 514);
        chk("replay_log_t", int'(tr[2].lt), 11);
        chk("replay_log_m", int'(tr[2].lm), 0);
        chk("replay_issue", int'(tr[2].issue), 1);

`ifdef NTT_CTRL_STALL_EN
        // Freeze 10 cycles while stage 3 counter sits at 17.
        tick();
        capture(700, -1, 138, 10, d);
        chk("stall_latency", d, 524);
        bad = 0;
        for (int c = 139; c <= 148; c++) begin
            if (tr[c].issue !== 1'b0 || tr[c].a0 !== 9'd17) bad++;
        end
        chk("stall_hold_bad", bad, 0);
        chk("stall_pre_addr", int'(tr[138].a0), 16);
        chk("stall_resume_addr", int'(tr[149].a0), 17);
        chk("stall_resume_issue", int'(tr[149].issue), 1);
        chk("stall_log_t", int'(tr[149].lt), 8);
`endif

        // Override instance: A=64, one drain cycle.
        tick();
        d = -1;
        b1.start = 1'b1;
        for (int c = 1; c <= 1000; c++) begin
            tick();
            b1.start = 1'b0;
            if (c == 65) chk("p64_addr63", int'(b1.address_0), 63);
            if (c == 66) chk("p64_drain_issue", int'(b1.issue), 0);
            if (c == 67) begin
                chk("p64_stage1_addr", int'(b1.address_0), 0);
                chk("p64_stage1_log_t", int'(b1.log_t), 10);
            end
            if (b1.done && d < 0) begin
                d = c;
                break;
            end
        end
        chk("p64_latency", d, 846);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
